flag_ctrl: RTL

- Owns the processor's N/V/Z condition-flag register and gates which ALU results may update it, per opcode.
- Evaluates branch conditions for the decode stage, forwarding flags from the instruction currently in EX.
- Freezes all flag state once HLT reaches EX.
- Sits beside the EX-stage ALU; consumes the ALU's combinational flag output and the EX opcode, and drives the branch-taken decision into the fetch/decode logic.

---
 rtl/flag_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/flag_ctrl.sv
// flag_ctrl
//   Holds the N/V/Z condition-flag register and decides which EX-stage ALU
//   results may update it. It also resolves decode-stage conditional branches
//   against flags forwarded from EX, and freezes all flag state once HLT
//   retires from EX.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   ex_vld     : EX holds a real instruction (not a bubble)
//   ex_stall   : EX is held this cycle
//   ex_flush   : EX instruction is squashed this cycle
//   ex_opcode  : EX instruction opcode
//   alu_flag   : combinational {N,V,Z} from the ALU
//   id_br_vld  : decode holds a conditional branch
//   id_ccc     : branch condition code
//   flag_q     : architectural flags {N,V,Z}
//   flag_wen   : per-bit flag write enable applied this cycle
//   take_br    : decode branch resolves taken
//   halted     : processor is halted
module flag_ctrl #(
   parameter int FLAG_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_vld,
   input  logic              ex_stall,
   input  logic              ex_flush,
   input  logic [3:0]        ex_opcode,
   input  logic [FLAG_W-1:0] alu_flag,
   input  logic              id_br_vld,
   input  logic [2:0]        id_ccc,
   output logic [FLAG_W-1:0] flag_q,
   output logic [FLAG_W-1:0] flag_wen,
   output logic              take_br,
   output logic              halted
);

   localparam int N_B = 2;
   localparam int V_B = 1;
   localparam int Z_B = 0;

   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

   state_e            state_q, state_d;
   logic [FLAG_W-1:0] flag_d;
   logic [FLAG_W-1:0] eff;
   logic              live;
   logic              n, v, z, cond;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         flag_q  <= '0;
      end else begin
         state_q <= state_d;
         flag_q  <= flag_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      flag_wen = '0;
      cond     = 1'b0;

      // Only an instruction that actually retires from EX this cycle may
      // write flags, forward flags, or halt the machine.
      live = ex_vld & ~ex_stall & ~ex_flush & (state_q == RUN);

      if (live) begin
         unique case (ex_opcode)
            4'b0000, 4'b0001:                   flag_wen = '1;               // ADD, SUB
            4'b0010, 4'b0100, 4'b0101, 4'b0110: flag_wen[Z_B] = 1'b1;        // XOR, SLL, SRA, ROR
            default:                            flag_wen = '0;
         endcase
         if (ex_opcode == 4'b1111) state_d = HALTED;
      end

      // Forwarded flags equal the next register value. A branch in ID can
      // therefore resolve against the EX result without a bubble.
      eff    = (flag_wen & alu_flag) | (~flag_wen & flag_q);
      flag_d = eff;

      n = eff[N_B];
      v = eff[V_B];
      z = eff[Z_B];
      unique case (id_ccc)
         3'b000: cond = ~z;
         3'b001: cond = z;
         3'b010: cond = ~z & ~n;
         3'b011: cond = n;
         3'b100: cond = z | (~z & ~n);
         3'b101: cond = n | z;
         3'b110: cond = v;
         default: cond = 1'b1;
      endcase

      take_br = id_br_vld & (state_q == RUN) & cond;
   end

   assign halted = (state_q == HALTED);

endmodule
